// File: rtl/switch_pkg.sv
// Shared types and sizing for the fixed-length switch (ingress VOQ, crossbar, scheduler).
package switch_pkg;

  localparam int unsigned NUM_PORTS     = 4;
  localparam int unsigned PORT_W        = 2;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_PKT_WORDS = 4;

  typedef enum logic {
    E_IDLE,
    E_FILL
  } enq_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_READ,
    D_DRAIN
  } deq_state_e;

endpackage

// File: rtl/voq_ram.sv
// Simple dual-port packet RAM: one write port, one read port, 1-cycle read latency.
// No read-during-write bypass; the VOQ slot accounting keeps the two addresses apart.
//   we/waddr/wdata : synchronous write
//   re/raddr       : read issue; rdata valid the following cycle and held otherwise
module voq_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array, never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register, cleared so the crossbar sees zero data out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ingress_voq.sv
// Ingress virtual output queue buffer: files fixed-length packets from the MAC into
// one of four VOQs by destination and streams the granted VOQ's head packet out.
//   enq_*        : word-by-word packet input; enq_dest sampled on the first word
//   sched_sel*   : grant from the scheduler for this ingress port
//   is_busy, busy_voq_num, voq_empty : status toward the scheduler
//   deq_*        : packet words to the crossbar
//   grant_err    : sticky flag for illegal grants
module ingress_voq
  import switch_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned PKT_WORDS = DEF_PKT_WORDS,
  parameter int unsigned VOQ_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [DATA_W-1:0]    enq_data,
  input  logic [PORT_W-1:0]    enq_dest,
  input  logic                 sched_sel_en,
  input  logic [PORT_W-1:0]    sched_sel,
  output logic                 is_busy,
  output logic [PORT_W-1:0]    busy_voq_num,
  output logic [NUM_PORTS-1:0] voq_empty,
  output logic                 deq_valid,
  output logic [DATA_W-1:0]    deq_data,
  output logic [PORT_W-1:0]    deq_egress,
  output logic                 deq_last,
  output logic                 grant_err
);

  localparam int unsigned WORD_W = $clog2(PKT_WORDS);
  localparam int unsigned SLOT_W = $clog2(VOQ_DEPTH);
  localparam int unsigned CNT_W  = SLOT_W + 1;
  localparam int unsigned ADDR_W = PORT_W + SLOT_W + WORD_W;

  // Enqueue side state
  enq_state_e          enq_state_q, enq_state_d;
  logic [PORT_W-1:0]   enq_dest_q, enq_dest_d;
  logic [WORD_W-1:0]   enq_word_q, enq_word_d;

  // Dequeue side state
  deq_state_e          deq_state_q, deq_state_d;
  logic [WORD_W-1:0]   rd_word_q, rd_word_d;
  logic                is_busy_q, is_busy_d;
  logic [PORT_W-1:0]   busy_voq_q, busy_voq_d;
  logic                deq_valid_q, deq_valid_d;
  logic [PORT_W-1:0]   deq_egress_q, deq_egress_d;
  logic                deq_last_q, deq_last_d;
  logic                grant_err_q, grant_err_d;

  // Per-VOQ bookkeeping
  logic [SLOT_W-1:0]   wr_slot_q [NUM_PORTS];
  logic [SLOT_W-1:0]   wr_slot_d [NUM_PORTS];
  logic [SLOT_W-1:0]   rd_slot_q [NUM_PORTS];
  logic [SLOT_W-1:0]   rd_slot_d [NUM_PORTS];
  logic [CNT_W-1:0]    pkt_cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]    pkt_cnt_d [NUM_PORTS];
  logic [CNT_W-1:0]    occ_q     [NUM_PORTS];
  logic [CNT_W-1:0]    occ_d     [NUM_PORTS];
  logic [NUM_PORTS-1:0] voq_empty_q, voq_empty_d;

  // Events between the FSMs and the counters
  logic                enq_ready_c;
  logic [PORT_W-1:0]   enq_voq_c;
  logic                enq_first_c;
  logic                enq_commit_c;
  logic                grant_c;
  logic                rd_done_c;
  logic                drain_c;

  // RAM ports
  logic                ram_we_c;
  logic [ADDR_W-1:0]   ram_waddr_c;
  logic                ram_re_c;
  logic [ADDR_W-1:0]   ram_raddr_c;
  logic [DATA_W-1:0]   ram_rdata;

  // Enqueue FSM: first word reserves a slot, last word commits the packet.
  always_comb begin
    enq_state_d  = enq_state_q;
    enq_dest_d   = enq_dest_q;
    enq_word_d   = enq_word_q;
    enq_ready_c  = 1'b1;
    enq_voq_c    = enq_dest_q;
    enq_first_c  = 1'b0;
    enq_commit_c = 1'b0;
    ram_we_c     = 1'b0;
    ram_waddr_c  = '0;
    case (enq_state_q)
      E_IDLE: begin
        enq_voq_c   = enq_dest;
        enq_ready_c = (occ_q[enq_dest] < CNT_W'(VOQ_DEPTH));
        if (enq_valid && enq_ready_c) begin
          ram_we_c    = 1'b1;
          ram_waddr_c = {enq_dest, wr_slot_q[enq_dest], WORD_W'(0)};
          enq_first_c = 1'b1;
          enq_dest_d  = enq_dest;
          enq_word_d  = WORD_W'(1);
          enq_state_d = E_FILL;
        end
      end
      E_FILL: begin
        if (enq_valid) begin
          ram_we_c    = 1'b1;
          ram_waddr_c = {enq_dest_q, wr_slot_q[enq_dest_q], enq_word_q};
          enq_word_d  = enq_word_q + WORD_W'(1);
          if (enq_word_q == WORD_W'(PKT_WORDS - 1)) begin
            enq_commit_c = 1'b1;
            enq_word_d   = '0;
            enq_state_d  = E_IDLE;
          end
        end
      end
      default: enq_state_d = E_IDLE;
    endcase
  end

  // Dequeue FSM: accept grant, issue PKT_WORDS reads, then drain the last RAM word.
  always_comb begin
    deq_state_d  = deq_state_q;
    rd_word_d    = rd_word_q;
    is_busy_d    = is_busy_q;
    busy_voq_d   = busy_voq_q;
    grant_err_d  = grant_err_q;
    deq_valid_d  = 1'b0;
    deq_last_d   = 1'b0;
    deq_egress_d = deq_egress_q;
    grant_c      = 1'b0;
    rd_done_c    = 1'b0;
    drain_c      = 1'b0;
    ram_re_c     = 1'b0;
    ram_raddr_c  = '0;
    case (deq_state_q)
      D_IDLE: begin
        if (sched_sel_en) begin
          if (pkt_cnt_q[sched_sel] != '0) begin
            grant_c     = 1'b1;
            busy_voq_d  = sched_sel;
            is_busy_d   = 1'b1;
            rd_word_d   = '0;
            deq_state_d = D_READ;
          end else begin
            grant_err_d = 1'b1;
          end
        end
      end
      D_READ: begin
        ram_re_c     = 1'b1;
        ram_raddr_c  = {busy_voq_q, rd_slot_q[busy_voq_q], rd_word_q};
        deq_valid_d  = 1'b1;
        deq_egress_d = busy_voq_q;
        rd_word_d    = rd_word_q + WORD_W'(1);
        if (rd_word_q == WORD_W'(PKT_WORDS - 1)) begin
          deq_last_d  = 1'b1;
          rd_done_c   = 1'b1;
          rd_word_d   = '0;
          deq_state_d = D_DRAIN;
        end
      end
      D_DRAIN: begin
        drain_c     = 1'b1;
        is_busy_d   = 1'b0;
        deq_state_d = D_IDLE;
      end
      default: deq_state_d = D_IDLE;
    endcase
    // A busy port may be re-granted its own VOQ; any other grant is illegal.
    if ((deq_state_q != D_IDLE) && sched_sel_en && (sched_sel != busy_voq_q)) begin
      grant_err_d = 1'b1;
    end
  end

  // Per-VOQ counters; simultaneous inc/dec on one VOQ cancel out.
  always_comb begin
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    pkt_cnt_d   = pkt_cnt_q;
    occ_d       = occ_q;
    voq_empty_d = voq_empty_q;
    for (int v = 0; v < NUM_PORTS; v++) begin
      pkt_cnt_d[v] = pkt_cnt_q[v]
                   + CNT_W'(enq_commit_c && (enq_voq_c == PORT_W'(v)))
                   - CNT_W'(grant_c && (sched_sel == PORT_W'(v)));
      occ_d[v]     = occ_q[v]
                   + CNT_W'(enq_first_c && (enq_voq_c == PORT_W'(v)))
                   - CNT_W'(drain_c && (busy_voq_q == PORT_W'(v)));
      wr_slot_d[v] = wr_slot_q[v] + SLOT_W'(enq_commit_c && (enq_voq_c == PORT_W'(v)));
      rd_slot_d[v] = rd_slot_q[v] + SLOT_W'(rd_done_c && (busy_voq_q == PORT_W'(v)));
      voq_empty_d[v] = (pkt_cnt_d[v] == '0);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enq_state_q  <= E_IDLE;
      enq_dest_q   <= '0;
      enq_word_q   <= '0;
      deq_state_q  <= D_IDLE;
      rd_word_q    <= '0;
      is_busy_q    <= 1'b0;
      busy_voq_q   <= '0;
      deq_valid_q  <= 1'b0;
      deq_egress_q <= '0;
      deq_last_q   <= 1'b0;
      grant_err_q  <= 1'b0;
      wr_slot_q    <= '{default: '0};
      rd_slot_q    <= '{default: '0};
      pkt_cnt_q    <= '{default: '0};
      occ_q        <= '{default: '0};
      voq_empty_q  <= '1;
    end else begin
      enq_state_q  <= enq_state_d;
      enq_dest_q   <= enq_dest_d;
      enq_word_q   <= enq_word_d;
      deq_state_q  <= deq_state_d;
      rd_word_q    <= rd_word_d;
      is_busy_q    <= is_busy_d;
      busy_voq_q   <= busy_voq_d;
      deq_valid_q  <= deq_valid_d;
      deq_egress_q <= deq_egress_d;
      deq_last_q   <= deq_last_d;
      grant_err_q  <= grant_err_d;
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      pkt_cnt_q    <= pkt_cnt_d;
      occ_q        <= occ_d;
      voq_empty_q  <= voq_empty_d;
    end
  end

  voq_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (enq_data),
    .re    (ram_re_c),
    .raddr (ram_raddr_c),
    .rdata (ram_rdata)
  );

  // enq_ready depends on the presented destination, so it stays combinational.
  assign enq_ready    = enq_ready_c;
  assign is_busy      = is_busy_q;
  assign busy_voq_num = busy_voq_q;
  assign voq_empty    = voq_empty_q;
  assign deq_valid    = deq_valid_q;
  assign deq_data     = ram_rdata;
  assign deq_egress   = deq_egress_q;
  assign deq_last     = deq_last_q;
  assign grant_err    = grant_err_q;

endmodule

// File: tb/tb_ingress_voq.sv
// Self-checking bench for ingress_voq: a per-cycle vector table, directed corner
// sequences, and a randomized run against a queue-based reference model.
module tb_ingress_voq;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 4;
  localparam int unsigned VD = 8;

  logic          clk;
  logic          rst_n;
  logic          enq_valid;
  logic          enq_ready;
  logic [DW-1:0] enq_data;
  logic [1:0]    enq_dest;
  logic          sched_sel_en;
  logic [1:0]    sched_sel;
  logic          is_busy;
  logic [1:0]    busy_voq_num;
  logic [3:0]    voq_empty;
  logic          deq_valid;
  logic [DW-1:0] deq_data;
  logic [1:0]    deq_egress;
  logic          deq_last;
  logic          grant_err;

  int total = 0;
  int bad   = 0;

  ingress_voq #(.DATA_W(DW), .PKT_WORDS(PW), .VOQ_DEPTH(VD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_data     (enq_data),
    .enq_dest     (enq_dest),
    .sched_sel_en (sched_sel_en),
    .sched_sel    (sched_sel),
    .is_busy      (is_busy),
    .busy_voq_num (busy_voq_num),
    .voq_empty    (voq_empty),
    .deq_valid    (deq_valid),
    .deq_data     (deq_data),
    .deq_egress   (deq_egress),
    .deq_last     (deq_last),
    .grant_err    (grant_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pw(input int id, input int w);
    logic [7:0] a;
    logic [7:0] b;
    a = id[7:0];
    b = w[7:0];
    return {16'hC0DE, a, b};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    enq_valid = 1'b0; enq_data = '0; enq_dest = '0;
    sched_sel_en = 1'b0; sched_sel = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Send one packet; waits (bounded) for enq_ready on the first word.
  task automatic send_pkt(input int dest, input int id);
    int waited;
    waited = 0;
    enq_valid = 1'b1;
    enq_dest  = 2'(dest);
    enq_data  = pw(id, 0);
    #1;
    while (!enq_ready && waited < 200) begin
      step();
      #1;
      waited++;
    end
    chk("send_first_ready", enq_ready, 1);
    step();
    for (int w = 1; w < PW; w++) begin
      enq_data = pw(id, w);
      enq_dest = 2'($urandom_range(0, 3));
      #1;
      chk("fill_ready", enq_ready, 1);
      step();
    end
    enq_valid = 1'b0;
    enq_data  = '0;
  endtask

  // Called at the falling edge of T+1 after a grant at T; checks the whole transfer.
  task automatic check_xfer(input int v, input int id, input bit chk_rdy);
    for (int k = 1; k <= PW + 2; k++) begin
      #1;
      chk("xfer_busy", is_busy, (k <= PW + 1));
      if (k <= PW + 1) chk("xfer_busy_voq", busy_voq_num, v);
      chk("xfer_valid", deq_valid, (k >= 2 && k <= PW + 1));
      if (k >= 2 && k <= PW + 1) begin
        chk("xfer_data", deq_data, pw(id, k - 2));
        chk("xfer_egress", deq_egress, v);
        chk("xfer_last", deq_last, (k == PW + 1));
      end
      if (chk_rdy) chk("full_ready", enq_ready, (k == PW + 2));
      if (k < PW + 2) step();
    end
  endtask

  task automatic do_grant(input int v, input int id, input bit chk_rdy);
    sched_sel_en = 1'b1;
    sched_sel    = 2'(v);
    step();
    sched_sel_en = 1'b0;
    check_xfer(v, id, chk_rdy);
  endtask

  typedef struct {
    logic          ev;   logic [1:0] ed;   logic [DW-1:0] edat;
    logic          gen;  logic [1:0] gsel;
    logic          x_rdy; logic x_busy; logic [1:0] x_bvoq; logic [3:0] x_empty;
    logic          x_dv; logic [DW-1:0] x_data; logic [1:0] x_eg; logic x_last; logic x_err;
  } vec_t;

  function automatic vec_t mkv(input int ev, input int ed, input logic [DW-1:0] edat,
                               input int gen, input int gsel, input int rdy, input int busy,
                               input int bvoq, input int empty, input int dv,
                               input logic [DW-1:0] xd, input int eg, input int last,
                               input int err);
    vec_t r;
    r.ev = 1'(ev); r.ed = 2'(ed); r.edat = edat; r.gen = 1'(gen); r.gsel = 2'(gsel);
    r.x_rdy = 1'(rdy); r.x_busy = 1'(busy); r.x_bvoq = 2'(bvoq); r.x_empty = 4'(empty);
    r.x_dv = 1'(dv); r.x_data = xd; r.x_eg = 2'(eg); r.x_last = 1'(last); r.x_err = 1'(err);
    return r;
  endfunction

  // Reference model state for the randomized run
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [1:0]    eg;
    logic          last;
  } exp_t;

  logic [DW-1:0] m_pkts [4][$];
  logic [DW-1:0] m_fbuf [$];
  exp_t          exp_q  [$];
  int            m_occ  [4];
  bit            m_filling;
  int            m_fdest;
  int            m_busy_end;
  int            m_busy_voq;
  int            m_drain_cyc;
  bit            m_err;

  vec_t vt [$];

  initial begin
    vec_t v;
    int   sel;
    int   r;
    bit   busy;
    bit   exp_rdy;
    bit   hs;
    logic [3:0] exp_empty;
    exp_t e;

    rst_n = 1'b0;
    enq_valid = 1'b0; enq_data = '0; enq_dest = '0;
    sched_sel_en = 1'b0; sched_sel = '0;
    @(negedge clk);
    #1;
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_is_busy", is_busy, 0);
    chk("rst_voq_empty", voq_empty, 4'hF);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_grant_err", grant_err, 0);

    // One packet to VOQ 2, grant with a same-VOQ re-grant while busy, then an empty-VOQ grant.
    vt.push_back(mkv(1, 2, 32'hAAAA_0000, 0, 0, 1, 0, 0, 4'hF, 0, '0, 0, 0, 0));
    vt.push_back(mkv(1, 0, 32'hAAAA_0001, 0, 0, 1, 0, 0, 4'hF, 0, '0, 0, 0, 0));
    vt.push_back(mkv(1, 3, 32'hAAAA_0002, 0, 0, 1, 0, 0, 4'hF, 0, '0, 0, 0, 0));
    vt.push_back(mkv(1, 2, 32'hAAAA_0003, 0, 0, 1, 0, 0, 4'hF, 0, '0, 0, 0, 0));
    vt.push_back(mkv(0, 0, '0,           1, 2, 1, 0, 0, 4'hB, 0, '0, 0, 0, 0));
    vt.push_back(mkv(0, 0, '0,           1, 2, 1, 1, 2, 4'hF, 0, '0, 0, 0, 0));
    vt.push_back(mkv(0, 0, '0,           0, 0, 1, 1, 2, 4'hF, 1, 32'hAAAA_0000, 2, 0, 0));
    vt.push_back(mkv(0, 0, '0,           0, 0, 1, 1, 2, 4'hF, 1, 32'hAAAA_0001, 2, 0, 0));
    vt.push_back(mkv(0, 0, '0,           0, 0, 1, 1, 2, 4'hF, 1, 32'hAAAA_0002, 2, 0, 0));
    vt.push_back(mkv(0, 0, '0,           0, 0, 1, 1, 2, 4'hF, 1, 32'hAAAA_0003, 2, 1, 0));
    vt.push_back(mkv(0, 0, '0,           1, 3, 1, 0, 0, 4'hF, 0, '0, 0, 0, 0));
    vt.push_back(mkv(0, 0, '0,           0, 0, 1, 0, 0, 4'hF, 0, '0, 0, 0, 1));
    vt.push_back(mkv(0, 0, '0,           0, 0, 1, 0, 0, 4'hF, 0, '0, 0, 0, 1));

    apply_reset();
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      enq_valid = v.ev; enq_dest = v.ed; enq_data = v.edat;
      sched_sel_en = v.gen; sched_sel = v.gsel;
      #1;
      chk($sformatf("vec%0d_ready", i), enq_ready, v.x_rdy);
      chk($sformatf("vec%0d_busy", i), is_busy, v.x_busy);
      if (v.x_busy) chk($sformatf("vec%0d_bvoq", i), busy_voq_num, v.x_bvoq);
      chk($sformatf("vec%0d_empty", i), voq_empty, v.x_empty);
      chk($sformatf("vec%0d_dv", i), deq_valid, v.x_dv);
      if (v.x_dv) begin
        chk($sformatf("vec%0d_data", i), deq_data, v.x_data);
        chk($sformatf("vec%0d_eg", i), deq_egress, v.x_eg);
        chk($sformatf("vec%0d_last", i), deq_last, v.x_last);
      end
      chk($sformatf("vec%0d_err", i), grant_err, v.x_err);
      step();
    end
    enq_valid = 1'b0; sched_sel_en = 1'b0;

    // Fill VOQ 1, hit full, free a slot, and round-trip 10 packets across the wrap.
    apply_reset();
    for (int p = 0; p < 8; p++) send_pkt(1, p);
    #1;
    chk("full_not_empty", voq_empty[1], 0);
    enq_valid = 1'b1; enq_dest = 2'd1; enq_data = pw(8, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("full_blocked", enq_ready, 0);
      step();
    end
    do_grant(1, 0, 1'b1);
    send_pkt(1, 8);
    do_grant(1, 1, 1'b0);
    send_pkt(1, 9);
    for (int p = 2; p < 10; p++) do_grant(1, p, 1'b0);
    step();
    #1;
    chk("wrap_all_empty", voq_empty, 4'hF);
    chk("wrap_no_err", grant_err, 0);

    // Same-VOQ re-grant while busy is legal; a different VOQ is not.
    apply_reset();
    send_pkt(0, 16);
    sched_sel_en = 1'b1; sched_sel = 2'd0;
    step();
    #1;
    chk("busy_self_busy", is_busy, 1);
    step();
    #1;
    chk("busy_self_no_err", grant_err, 0);
    chk("busy_self_word0", deq_data, pw(16, 0));
    sched_sel = 2'd1;
    step();
    sched_sel_en = 1'b0;
    #1;
    chk("busy_other_err", grant_err, 1);
    chk("busy_other_word1", deq_data, pw(16, 1));
    repeat (6) step();
    #1;
    chk("busy_err_sticky", grant_err, 1);
    chk("busy_done", is_busy, 0);

    // Commit and grant on the same VOQ in the same cycle.
    apply_reset();
    send_pkt(0, 32);
    enq_valid = 1'b1; enq_dest = 2'd0;
    for (int w = 0; w < PW; w++) begin
      enq_data = pw(33, w);
      if (w == PW - 1) begin
        sched_sel_en = 1'b1; sched_sel = 2'd0;
      end
      step();
    end
    enq_valid = 1'b0; sched_sel_en = 1'b0;
    #1;
    chk("coll_not_empty", voq_empty[0], 0);
    check_xfer(0, 32, 1'b0);
    do_grant(0, 33, 1'b0);
    step();
    #1;
    chk("coll_empty_after", voq_empty, 4'hF);
    chk("coll_no_err", grant_err, 0);

    // Reset in the middle of a transfer.
    apply_reset();
    send_pkt(3, 48);
    sched_sel_en = 1'b1; sched_sel = 2'd3;
    step();
    sched_sel_en = 1'b0;
    repeat (3) step();
    #1;
    chk("mid_word2", deq_data, pw(48, 2));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", enq_ready, 1);
    chk("mid_rst_busy", is_busy, 0);
    chk("mid_rst_bvoq", busy_voq_num, 0);
    chk("mid_rst_empty", voq_empty, 4'hF);
    chk("mid_rst_dv", deq_valid, 0);
    chk("mid_rst_data", deq_data, 0);
    chk("mid_rst_eg", deq_egress, 0);
    chk("mid_rst_last", deq_last, 0);
    chk("mid_rst_err", grant_err, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      chk("post_rst_dv", deq_valid, 0);
      chk("post_rst_busy", is_busy, 0);
    end

    // Randomized traffic against the reference model.
    apply_reset();
    for (int q = 0; q < 4; q++) begin
      m_pkts[q].delete();
      m_occ[q] = 0;
    end
    m_fbuf.delete(); exp_q.delete();
    m_filling = 1'b0; m_fdest = 0; m_busy_end = 0; m_busy_voq = 0;
    m_drain_cyc = -1; m_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      busy = (c < m_busy_end);
      enq_valid = ($urandom_range(0, 3) != 0);
      enq_dest  = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom_range(0, 3));
      enq_data  = $urandom;
      sched_sel_en = 1'b0;
      sched_sel    = 2'($urandom_range(0, 3));
      if (!busy && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 3);
        sel = -1;
        for (int i = 0; i < 4; i++)
          if (sel < 0 && m_pkts[(r + i) % 4].size() > 0) sel = (r + i) % 4;
        if (sel >= 0) begin
          sched_sel_en = 1'b1; sched_sel = 2'(sel);
        end
      end else if (busy && $urandom_range(0, 3) == 0) begin
        sched_sel_en = 1'b1; sched_sel = 2'(m_busy_voq);
      end
      #1;
      chk("rnd_busy", is_busy, busy);
      if (busy) chk("rnd_bvoq", busy_voq_num, m_busy_voq);
      for (int q = 0; q < 4; q++) exp_empty[q] = (m_pkts[q].size() == 0);
      chk("rnd_empty", voq_empty, exp_empty);
      chk("rnd_err", grant_err, m_err);
      if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        chk("rnd_dv", deq_valid, 1);
        chk("rnd_data", deq_data, e.data);
        chk("rnd_eg", deq_egress, e.eg);
        chk("rnd_last", deq_last, e.last);
      end else begin
        chk("rnd_dv", deq_valid, 0);
      end
      exp_rdy = m_filling ? 1'b1 : (m_occ[enq_dest] < VD);
      chk("rnd_ready", enq_ready, exp_rdy);
      hs = enq_valid && exp_rdy;

      // Model update for the edge that ends this cycle.
      if (m_drain_cyc == c) m_occ[m_busy_voq]--;
      if (sched_sel_en) begin
        if (busy) begin
          if (int'(sched_sel) != m_busy_voq) m_err = 1'b1;
        end else if (m_pkts[sched_sel].size() > 0) begin
          for (int w = 0; w < PW; w++) begin
            e.cyc  = c + 2 + w;
            e.data = m_pkts[sched_sel].pop_front();
            e.eg   = sched_sel;
            e.last = (w == PW - 1);
            exp_q.push_back(e);
          end
          m_busy_voq  = int'(sched_sel);
          m_busy_end  = c + PW + 2;
          m_drain_cyc = c + PW + 1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (hs) begin
        if (!m_filling) begin
          m_filling = 1'b1;
          m_fdest   = int'(enq_dest);
          m_occ[m_fdest]++;
          m_fbuf.delete();
        end
        m_fbuf.push_back(enq_data);
        if (m_fbuf.size() == PW) begin
          foreach (m_fbuf[i]) m_pkts[m_fdest].push_back(m_fbuf[i]);
          m_filling = 1'b0;
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
